prio_sel_arb: RTL and testbench

Parametrised, registered N-channel priority selector. It is the sequential successor to the team's fixed five-select combinational priority mux. Each cycle it picks one requesting channel, using either fixed priority (channel 0 highest) or round-robin, and captures that channel's data into an output register. The register has a valid/ready handshake and returns a one-hot grant to the sources. It sits between several data producers and a single downstream consumer.

---
 rtl/prio_sel_arb.sv | 126 ++++++++++++
 tb/tb_prio_sel_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/prio_sel_arb.sv
// prio_sel_arb: registered N-channel priority selector.
//
// Each cycle one requesting channel is chosen, by fixed priority (channel 0
// highest) or by round-robin, and its data word is captured into a single
// output register that is drained through a valid/ready handshake. A
// combinational one-hot grant tells the sources which word was taken.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst_n      in   1              synchronous active-low reset
//   mode       in   1              0 = fixed priority, 1 = round-robin
//   req        in   N_CH           per-channel request
//   din        in   N_CH*WIDTH     channel i data at din[i*WIDTH +: WIDTH]
//   gnt        out  N_CH           one-hot grant, data captured on this edge
//   out_valid  out  1              dout/gnt_idx hold a word
//   out_ready  in   1              consumer accepts the word this cycle
//   dout       out  WIDTH          registered selected data
//   gnt_idx    out  IDXW           registered index of the selected channel
module prio_sel_arb #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_CH  = 6,
    parameter int unsigned IDXW  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*WIDTH-1:0]   din,
    output logic [N_CH-1:0]         gnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [IDXW-1:0]         gnt_idx
);

    // Output register and round-robin pointer.
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  r_ptr;

    // Arbitration results.
    logic             w_load;
    logic             w_fp_found;
    logic [IDXW-1:0]  w_fp_win;
    logic             w_rr_found;
    logic [IDXW-1:0]  w_rr_win;
    logic             w_found;
    logic [IDXW-1:0]  w_win;
    logic [N_CH-1:0]  w_onehot;
    logic [WIDTH-1:0] w_data;
    logic [IDXW-1:0]  w_ptr_next;

    // Register may take a new word when empty or being drained this cycle.
    assign w_load = !r_valid || out_ready;

    // Fixed priority: lowest requesting index.
    always_comb begin
        w_fp_found = 1'b0;
        w_fp_win   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (req[i] && !w_fp_found) begin
                w_fp_found = 1'b1;
                w_fp_win   = IDXW'(i);
            end
        end
    end

    // Round-robin: first requester found walking from r_ptr upward with
    // wrap. r_ptr is always < N_CH, so a single subtraction wraps the sum.
    always_comb begin
        int unsigned j;
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        j          = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (req[j] && !w_rr_found) begin
                w_rr_found = 1'b1;
                w_rr_win   = IDXW'(j);
            end
        end
    end

    always_comb begin
        w_found  = mode ? w_rr_found : w_fp_found;
        w_win    = mode ? w_rr_win   : w_fp_win;
        w_onehot = '0;
        w_onehot[w_win] = 1'b1;
    end

    assign w_data     = din[int'(w_win)*WIDTH +: WIDTH];
    assign w_ptr_next = (w_win == IDXW'(N_CH - 1)) ? '0 : w_win + 1'b1;

    // Grant is suppressed during reset, under stall, and with no requests.
    assign gnt = (rst_n && w_load && w_found) ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_dout  <= w_data;
                r_idx   <= w_win;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                // dout/gnt_idx keep their last value when emptied.
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign dout      = r_dout;
    assign gnt_idx   = r_idx;

endmodule

// File: tb/tb_prio_sel_arb.sv
module tb_prio_sel_arb;

    localparam int N  = 6;
    localparam int W  = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    dout;
    logic [IW-1:0]   gnt_idx;

    prio_sel_arb #(.WIDTH(W), .N_CH(N), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int  m_ptr   = 0;
    bit  m_valid = 0;
    int  q_idx[$];
    int  q_dat[$];

    localparam logic [N*W-1:0] D_RAMP = 24'h543210;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    // Index of the chosen channel, or -1 when nobody requests.
    function automatic int pick(bit m, logic [N-1:0] rq);
        for (int k = 0; k < N; k++) begin
            int i;
            i = m ? (m_ptr + k) % N : k;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: drive at posedge+1, check gnt/out_valid, update model.
    task automatic step(input bit r, input bit m, input logic [N-1:0] rq,
                        input logic [N*W-1:0] d, input bit rd);
        int w;
        int eg;
        bit ld;
        rst_n = r; mode = m; req = rq; din = d; out_ready = rd;
        #1;
        ld = !m_valid || rd;
        w  = (r && ld) ? pick(m, rq) : -1;
        eg = (w >= 0) ? (1 << w) : 0;
        chk("gnt", int'(gnt), eg);
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (!r) begin
            m_valid = 0;
            m_ptr   = 0;
            q_idx.delete();
            q_dat.delete();
        end else if (ld) begin
            if (w >= 0) begin
                logic [W-1:0] sl;
                sl = d[w*W +: W];
                q_idx.push_back(w);
                q_dat.push_back(int'(sl));
                m_valid = 1;
                if (m) m_ptr = (w + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word the consumer accepts must match the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (q_idx.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("gnt_idx", int'(gnt_idx), q_idx.pop_front());
                chk("dout", int'(dout), q_dat.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; req = '0; din = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with all channels requesting.
        step(0, 0, 6'b111111, D_RAMP, 1);
        step(0, 0, 6'b111111, D_RAMP, 1);
        chk("rst_dout", int'(dout), 0);
        chk("rst_gnt_idx", int'(gnt_idx), 0);
        step(1, 0, 6'b111111, D_RAMP, 1);

        // Fixed priority with channels 1, 2, 4 requesting.
        repeat (3) step(1, 0, 6'b010110, D_RAMP, 1);
        step(1, 0, 6'b000000, D_RAMP, 1);
        step(1, 0, 6'b000000, D_RAMP, 1);
        chk("fp_dout_hold", int'(dout), 1);
        chk("fp_idx_hold", int'(gnt_idx), 1);

        // Round-robin across all channels, wrapping 5 -> 0.
        repeat (8) step(1, 1, 6'b111111, D_RAMP, 1);

        // Backpressure from a clean pointer.
        step(0, 1, 6'b000000, D_RAMP, 1);
        step(1, 1, 6'b100001, D_RAMP, 1);
        repeat (5) begin
            step(1, 1, 6'b100001, D_RAMP, 0);
            chk("bp_dout_hold", int'(dout), 0);
            chk("bp_idx_hold", int'(gnt_idx), 0);
        end
        step(1, 1, 6'b100001, D_RAMP, 1);
        step(1, 1, 6'b000000, D_RAMP, 1);

        // Mode switch: grant ch3 in round-robin, fixed picks ch0, back resumes at ch4.
        step(0, 1, 6'b000000, D_RAMP, 1);
        step(1, 1, 6'b001000, D_RAMP, 1);
        step(1, 0, 6'b000011, D_RAMP, 1);
        step(1, 1, 6'b111111, D_RAMP, 1);
        step(1, 1, 6'b000000, D_RAMP, 1);

        // Reset while a word is stalled: it must vanish and ptr must clear.
        step(1, 1, 6'b111111, D_RAMP, 1);
        step(1, 1, 6'b111111, D_RAMP, 0);
        step(1, 1, 6'b111111, D_RAMP, 0);
        step(0, 1, 6'b111111, D_RAMP, 0);
        step(1, 1, 6'b000000, D_RAMP, 1);
        step(1, 1, 6'b111111, D_RAMP, 1);

        // Randomised traffic.
        for (int t = 0; t < 3000; t++) begin
            bit          r, m, rd;
            logic [N-1:0] rq;
            logic [N*W-1:0] d;
            r  = ($urandom_range(0, 63) != 0);
            m  = ($urandom_range(0, 7) < 5);
            rd = ($urandom_range(0, 9) < 7);
            rq = N'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            d  = (N*W)'($urandom);
            step(r, m, rq, d, rd);
        end

        step(1, 0, 6'b000000, D_RAMP, 1);
        step(1, 0, 6'b000000, D_RAMP, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
